// File: rtl/board_arbiter.sv
// board_arbiter
//   Two-requester arbiter in front of the single-port board RAM. Requester A
//   (draw pipeline) only reads. Requester B (game control) reads or writes.
//   Each transaction walks IDLE -> ACCESS -> WAIT -> DONE, so the arbiter
//   completes at most one transaction every 4 cycles.
//
//   Optional feature: define BOARD_ARB_RR_EN to grant simultaneous requests
//   round-robin. Without it, A always wins a tie.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   req_a, addr_a        A read request (level) and cell address
//   gnt_a, ack_a         A grant pulse (ACCESS) and completion pulse (DONE)
//   rdata_a              last cell state read by A (00 empty/01 ship/10 hit/11 miss)
//   req_b, we_b          B request (level) and write enable
//   addr_b, wdata_b      B cell address and write data
//   gnt_b, ack_b, rdata_b  as for A
//   mem_en, mem_we, mem_addr, mem_wdata  RAM command, driven only in ACCESS
//   mem_rdata            RAM read data, valid one cycle after a read command
//   busy                 high whenever a transaction is in flight
module board_arbiter #(
  parameter int CELLS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [6:0] addr_a,
  output logic       gnt_a,
  output logic       ack_a,
  output logic [1:0] rdata_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [6:0] addr_b,
  input  logic [1:0] wdata_b,
  output logic       gnt_b,
  output logic       ack_b,
  output logic [1:0] rdata_b,
  output logic       mem_en,
  output logic       mem_we,
  output logic [6:0] mem_addr,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [7:0] CELLS_LIM = 8'(CELLS);

  state_t     state_q, state_d;
  logic       owner_b_q, owner_b_d;
  logic [6:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [1:0] wdata_q, wdata_d;
  logic [1:0] rdata_a_q, rdata_a_d;
  logic [1:0] rdata_b_q, rdata_b_d;
  logic       pick_b;
  logic       in_range;
`ifdef BOARD_ARB_RR_EN
  logic       last_b_q, last_b_d;
`endif

  assign in_range = ({1'b0, addr_q} < CELLS_LIM);
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

  // Owner selection for the current IDLE cycle.
  always_comb begin
`ifdef BOARD_ARB_RR_EN
    // On a tie, B wins only if A was the last owner.
    pick_b = req_b & (~req_a | ~last_b_q);
`else
    pick_b = ~req_a;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
`ifdef BOARD_ARB_RR_EN
    last_b_d  = last_b_q;
`endif
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 7'd0;
    mem_wdata = 2'd0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d   = ACCESS;
          owner_b_d = pick_b;
          addr_d    = pick_b ? addr_b : addr_a;
          we_d      = pick_b & we_b;
          wdata_d   = pick_b ? wdata_b : 2'd0;
`ifdef BOARD_ARB_RR_EN
          last_b_d  = pick_b;
`endif
        end
      end
      ACCESS: begin
        gnt_a   = ~owner_b_q;
        gnt_b   = owner_b_q;
        // Out-of-range cells never reach the RAM.
        if (in_range) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        // Out-of-range accesses report an empty cell; in-range writes
        // leave the owner's read register alone.
        if (!in_range) begin
          if (owner_b_q) rdata_b_d = 2'd0;
          else           rdata_a_d = 2'd0;
        end else if (!we_q) begin
          if (owner_b_q) rdata_b_d = mem_rdata;
          else           rdata_a_d = mem_rdata;
        end
        state_d = DONE;
      end
      DONE: begin
        ack_a   = ~owner_b_q;
        ack_b   = owner_b_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b0;
      addr_q    <= 7'd0;
      we_q      <= 1'b0;
      wdata_q   <= 2'd0;
      rdata_a_q <= 2'd0;
      rdata_b_q <= 2'd0;
`ifdef BOARD_ARB_RR_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_b_q <= owner_b_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
`ifdef BOARD_ARB_RR_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_board_arbiter.sv
// tb_board_arbiter
//   Bench for board_arbiter: a transaction-level reference model plus a
//   behavioural board RAM, compared against the DUT every falling edge, and
//   directed scenarios with literal expected values. Honours BOARD_ARB_RR_EN.
module tb_board_arbiter;

  localparam int CELLS = 100;
`ifdef BOARD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [6:0] addr_a = '0, addr_b = '0;
  logic [1:0] wdata_b = '0;
  logic       gnt_a, ack_a, gnt_b, ack_b;
  logic [1:0] rdata_a, rdata_b;
  logic       mem_en, mem_we, busy;
  logic [6:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  board_arbiter #(.CELLS(CELLS)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Board RAM: registered read, one-cycle latency.
  logic [1:0] ram [0:127];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) ram[i] <= 2'(i % 4);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit inr(input logic [6:0] a);
    return int'(a) < CELLS;
  endfunction

  function automatic bit choose_b(input bit ra, input bit rb, input bit lastb);
    if (ra && rb) return RR ? !lastb : 1'b0;
    return rb;
  endfunction

  // Reference model: one transaction at a time; m_off counts cycles since
  // the request was taken (1 = grant/RAM command, 3 = completion).
  bit         m_act, m_own_b, m_we, m_last_b;
  int         m_off;
  logic [6:0] m_addr;
  logic [1:0] m_wd, m_rd_a, m_rd_b;
  logic [1:0] mdl_mem [0:127];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act    <= 1'b0;
      m_off    <= 0;
      m_last_b <= 1'b1;
      m_rd_a   <= 2'd0;
      m_rd_b   <= 2'd0;
      if (load) for (int i = 0; i < 128; i++) mdl_mem[i] <= 2'(i % 4);
    end else if (!m_act) begin
      if (req_a || req_b) begin
        m_act   <= 1'b1;
        m_off   <= 1;
        m_own_b <= choose_b(req_a, req_b, m_last_b);
        m_addr  <= choose_b(req_a, req_b, m_last_b) ? addr_b : addr_a;
        m_we    <= choose_b(req_a, req_b, m_last_b) & we_b;
        m_wd    <= choose_b(req_a, req_b, m_last_b) ? wdata_b : 2'd0;
        if (RR) m_last_b <= choose_b(req_a, req_b, m_last_b);
      end
    end else begin
      m_off <= m_off + 1;
      if (m_off == 3) m_act <= 1'b0;
      if (m_off == 1 && m_we && inr(m_addr)) mdl_mem[m_addr] <= m_wd;
      if (m_off == 2) begin
        if (!inr(m_addr)) begin
          if (m_own_b) m_rd_b <= 2'd0; else m_rd_a <= 2'd0;
        end else if (!m_we) begin
          if (m_own_b) m_rd_b <= mdl_mem[m_addr]; else m_rd_a <= mdl_mem[m_addr];
        end
      end
    end
  end

  always @(negedge clk) begin
    bit acc, en;
    acc = m_act && (m_off == 1);
    en  = acc && inr(m_addr);
    chk("gnt_a",     gnt_a,     acc && !m_own_b);
    chk("gnt_b",     gnt_b,     acc && m_own_b);
    chk("ack_a",     ack_a,     m_act && m_off == 3 && !m_own_b);
    chk("ack_b",     ack_b,     m_act && m_off == 3 && m_own_b);
    chk("busy",      busy,      m_act);
    chk("mem_en",    mem_en,    en);
    chk("mem_we",    mem_we,    en && m_we);
    chk("mem_addr",  mem_addr,  en ? m_addr : 7'd0);
    chk("mem_wdata", mem_wdata, en ? m_wd : 2'd0);
    chk("rdata_a",   rdata_a,   m_rd_a);
    chk("rdata_b",   rdata_b,   m_rd_b);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] gb;
    int         k;
    bit         seen_en;

    // Reset and RAM preload.
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata_b", rdata_b, 2'd0);
    chk("rst_mem_en", mem_en, 1'b0);
    load = 1'b0;
    step();
    rst = 1'b1;
    step();

    // A reads cell 37 (preloaded 01).
    req_a = 1'b1; addr_a = 7'd37;
    step();
    chk("a37_gnt", gnt_a, 1'b1);
    chk("a37_mem_en", mem_en, 1'b1);
    chk("a37_mem_addr", mem_addr, 7'd37);
    req_a = 1'b0;
    step(); step();
    chk("a37_ack", ack_a, 1'b1);
    chk("a37_rdata", rdata_a, 2'b01);
    step();

    // B writes 10 to cell 5, then reads it back.
    req_b = 1'b1; we_b = 1'b1; addr_b = 7'd5; wdata_b = 2'b10;
    step();
    chk("bw_gnt", gnt_b, 1'b1);
    chk("bw_mem_we", mem_we, 1'b1);
    chk("bw_mem_wdata", mem_wdata, 2'b10);
    req_b = 1'b0; we_b = 1'b0; wdata_b = 2'b00;
    step(); step();
    chk("bw_ack", ack_b, 1'b1);
    chk("bw_rdata_b", rdata_b, 2'b00);
    step();
    req_b = 1'b1;
    step();
    chk("br_mem_we", mem_we, 1'b0);
    req_b = 1'b0;
    step(); step();
    chk("br_ack", ack_b, 1'b1);
    chk("br_rdata_b", rdata_b, 2'b10);
    chk("br_rdata_a", rdata_a, 2'b01);
    step();

    // B reads out-of-range cell 100.
    req_b = 1'b1; addr_b = 7'd100;
    seen_en = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      step();
      if (s == 1) req_b = 1'b0;
      if (mem_en) seen_en = 1'b1;
      if (s == 3) chk("oor_ack", ack_b, 1'b1);
    end
    chk("oor_mem_en", seen_en, 1'b0);
    chk("oor_rdata_b", rdata_b, 2'b00);

    // Contention for 16 cycles.
    req_a = 1'b1; addr_a = 7'd10; req_b = 1'b1; addr_b = 7'd11;
    gb = 4'b0; k = 0;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (gnt_a || gnt_b) begin
        if (k < 4) gb[k] = gnt_b;
        k++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("cont_grants", k, 4);
    chk("cont_order", gb, RR ? 4'b1010 : 4'b0000);
    step(); step(); step(); step();

    // Back-to-back A reads.
    req_a = 1'b1; addr_a = 7'd37;
    for (int s = 1; s <= 12; s++) begin
      step();
      chk("b2b_ack", ack_a, (s % 4) == 3);
      chk("b2b_busy", busy, (s % 4) != 0);
    end
    req_a = 1'b0;
    step();

    // Reset during WAIT of an A read with req_a held.
    req_a = 1'b1; addr_a = 7'd38;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_gnt_a", gnt_a, 1'b0);
    chk("rstw_ack_a", ack_a, 1'b0);
    chk("rstw_rdata_a", rdata_a, 2'b00);
    step(); step();
    rst = 1'b1;
    step();
    chk("rstw_regrant", gnt_a, 1'b1);
    req_a = 1'b0;
    step(); step();
    chk("rstw_ack", ack_a, 1'b1);
    chk("rstw_rdata", rdata_a, 2'b10);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
